ga_main_fsm: RTL and testbench

Top-level control FSM of the GA adaptive-filter accelerator. It counts incoming sample vectors and starts the initial population. Once cnfg_b samples are held, it runs cnfg_g generations through the GA algorithm block using request/done pulses. It then publishes the best chromosome as the next filter weights o_w_vec_np1 and the filter output o_y_n. Sits between the accelerator top ports and the algorithm datapath.

---
 rtl/ga_pkg.sv | 32 +++
 rtl/ga_dot_product.sv | 30 +++
 rtl/ga_main_fsm.sv | 131 +++++++++++++
 tb/tb_ga_main_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared parameters, derived widths and state encoding for the GA accelerator control path.
package ga_pkg;

    localparam int DATA_W      = 6;
    localparam int P_MAX       = 1024;
    localparam int M_MAX       = 32;
    localparam int B_MAX       = 64;
    localparam int G_MAX       = 1024;

    localparam int B_MAX_W     = $clog2(B_MAX + 1);
    localparam int G_MAX_W     = $clog2(G_MAX + 1);
    localparam int M_IDX_MAX_W = $clog2(M_MAX);
    localparam int CHROM_MAX_W = DATA_W * M_MAX;
    localparam int Y_W         = 2 * DATA_W + M_IDX_MAX_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        RUN,
        DONE
    } ga_state_t;

    // A zero configuration would never complete a run, so it behaves as one.
    function automatic logic [B_MAX_W-1:0] eff_b(input logic [B_MAX_W-1:0] b);
        return (b == '0) ? B_MAX_W'(1) : b;
    endfunction

    function automatic logic [G_MAX_W-1:0] eff_g(input logic [G_MAX_W-1:0] g);
        return (g == '0) ? G_MAX_W'(1) : g;
    endfunction

endpackage

// File: rtl/ga_dot_product.sv
// Combinational signed multiply-accumulate of two flat M_MAX-element vectors.
module ga_dot_product
    import ga_pkg::*;
(
    input  logic [CHROM_MAX_W-1:0] w_vec,
    input  logic [CHROM_MAX_W-1:0] v_vec,
    output logic [Y_W-1:0]         y
);

    logic signed [DATA_W-1:0]   w_el;
    logic signed [DATA_W-1:0]   v_el;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [Y_W-1:0]      acc;

    // Accumulator is wide enough for M_MAX full-scale products, so no overflow handling.
    always_comb begin
        w_el = '0;
        v_el = '0;
        prod = '0;
        acc  = '0;
        for (int i = 0; i < M_MAX; i++) begin
            w_el = w_vec[i*DATA_W +: DATA_W];
            v_el = v_vec[i*DATA_W +: DATA_W];
            prod = w_el * v_el;
            acc  = acc + Y_W'(prod);
        end
        y = acc;
    end

endmodule

// File: rtl/ga_main_fsm.sv
// Top-level GA control FSM: collects samples, sequences generations through the
// algorithm block and publishes the best chromosome plus filter output.
module ga_main_fsm
    import ga_pkg::*;
(
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [B_MAX_W-1:0]     cnfg_b,
    input  logic [G_MAX_W-1:0]     cnfg_g,
    input  logic                   i_ga_enable,
    input  logic                   i_valid_pls,
    input  logic [CHROM_MAX_W-1:0] i_v_vec_flat_n,
    output logic                   o_valid_lvl,
    output logic                   o_ga_ready,
    output logic [CHROM_MAX_W-1:0] o_w_vec_np1,
    output logic [Y_W-1:0]         o_y_n,
    output logic [B_MAX_W-1:0]     o_inputs_counter,
    input  logic                   algo_self_gen_created_pls,
    input  logic [CHROM_MAX_W-1:0] algo_self_best_chrom,
    output logic                   self_algo_init_pop_start,
    output logic                   self_algo_fit_enable,
    output logic                   self_algo_create_new_gen_req_pls,
    output logic                   self_algo_stop_create_new_gens_req_pls,
    output logic                   self_algo_chrom_mux_sel
);

    ga_state_t                state;
    logic [G_MAX_W-1:0]       gen_cnt;
    logic [CHROM_MAX_W-1:0]   v_reg;
    logic [CHROM_MAX_W-1:0]   chrom_reg;

    logic [B_MAX_W-1:0]       b_lim;
    logic [G_MAX_W-1:0]       g_lim;
    logic [B_MAX_W-1:0]       cnt_next;
    logic [G_MAX_W-1:0]       gen_next;
    logic [Y_W-1:0]           dot_y;

    assign b_lim    = eff_b(cnfg_b);
    assign g_lim    = eff_g(cnfg_g);
    assign cnt_next = (o_inputs_counter >= b_lim) ? b_lim : o_inputs_counter + B_MAX_W'(1);
    assign gen_next = gen_cnt + G_MAX_W'(1);

    ga_dot_product u_dot (
        .w_vec (chrom_reg),
        .v_vec (v_reg),
        .y     (dot_y)
    );

    // Pulses default low every cycle; published results survive a disable.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state                                  <= IDLE;
            gen_cnt                                <= '0;
            v_reg                                  <= '0;
            chrom_reg                              <= '0;
            o_valid_lvl                            <= 1'b0;
            o_ga_ready                             <= 1'b0;
            o_w_vec_np1                            <= '0;
            o_y_n                                  <= '0;
            o_inputs_counter                       <= '0;
            self_algo_init_pop_start               <= 1'b0;
            self_algo_fit_enable                   <= 1'b0;
            self_algo_create_new_gen_req_pls       <= 1'b0;
            self_algo_stop_create_new_gens_req_pls <= 1'b0;
            self_algo_chrom_mux_sel                <= 1'b0;
        end else begin
            self_algo_init_pop_start               <= 1'b0;
            self_algo_create_new_gen_req_pls       <= 1'b0;
            self_algo_stop_create_new_gens_req_pls <= 1'b0;

            if (!i_ga_enable) begin
                state                   <= IDLE;
                gen_cnt                 <= '0;
                o_inputs_counter        <= '0;
                o_valid_lvl             <= 1'b0;
                o_ga_ready              <= 1'b0;
                self_algo_fit_enable    <= 1'b0;
                self_algo_chrom_mux_sel <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        self_algo_init_pop_start <= 1'b1;
                        o_ga_ready               <= 1'b1;
                        state                    <= COLLECT;
                    end

                    COLLECT: begin
                        if (i_valid_pls) begin
                            v_reg            <= i_v_vec_flat_n;
                            o_inputs_counter <= cnt_next;
                            if (cnt_next == b_lim) begin
                                gen_cnt                          <= '0;
                                o_ga_ready                       <= 1'b0;
                                self_algo_chrom_mux_sel          <= 1'b1;
                                self_algo_fit_enable             <= 1'b1;
                                self_algo_create_new_gen_req_pls <= 1'b1;
                                state                            <= RUN;
                            end
                        end
                    end

                    // Each finished generation either requests another or ends the run.
                    RUN: begin
                        if (algo_self_gen_created_pls) begin
                            chrom_reg <= algo_self_best_chrom;
                            gen_cnt   <= gen_next;
                            if (gen_next >= g_lim) begin
                                self_algo_stop_create_new_gens_req_pls <= 1'b1;
                                self_algo_chrom_mux_sel                <= 1'b0;
                                state                                  <= DONE;
                            end else begin
                                self_algo_create_new_gen_req_pls <= 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        o_w_vec_np1 <= chrom_reg;
                        o_y_n       <= dot_y;
                        o_valid_lvl <= 1'b1;
                        o_ga_ready  <= 1'b1;
                        state       <= COLLECT;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ga_main_fsm.sv
// Directed bench for ga_main_fsm: a cycle-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ga_main_fsm;
    import ga_pkg::*;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [B_MAX_W-1:0]     cnfg_b;
    logic [G_MAX_W-1:0]     cnfg_g;
    logic                   i_ga_enable;
    logic                   i_valid_pls;
    logic [CHROM_MAX_W-1:0] i_v_vec_flat_n;
    logic                   o_valid_lvl;
    logic                   o_ga_ready;
    logic [CHROM_MAX_W-1:0] o_w_vec_np1;
    logic [Y_W-1:0]         o_y_n;
    logic [B_MAX_W-1:0]     o_inputs_counter;
    logic                   algo_self_gen_created_pls;
    logic [CHROM_MAX_W-1:0] algo_self_best_chrom;
    logic                   self_algo_init_pop_start;
    logic                   self_algo_fit_enable;
    logic                   self_algo_create_new_gen_req_pls;
    logic                   self_algo_stop_create_new_gens_req_pls;
    logic                   self_algo_chrom_mux_sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ga_main_fsm dut (
        .clk                                    (clk),
        .rstn                                   (rstn),
        .cnfg_b                                 (cnfg_b),
        .cnfg_g                                 (cnfg_g),
        .i_ga_enable                            (i_ga_enable),
        .i_valid_pls                            (i_valid_pls),
        .i_v_vec_flat_n                         (i_v_vec_flat_n),
        .o_valid_lvl                            (o_valid_lvl),
        .o_ga_ready                             (o_ga_ready),
        .o_w_vec_np1                            (o_w_vec_np1),
        .o_y_n                                  (o_y_n),
        .o_inputs_counter                       (o_inputs_counter),
        .algo_self_gen_created_pls              (algo_self_gen_created_pls),
        .algo_self_best_chrom                   (algo_self_best_chrom),
        .self_algo_init_pop_start               (self_algo_init_pop_start),
        .self_algo_fit_enable                   (self_algo_fit_enable),
        .self_algo_create_new_gen_req_pls       (self_algo_create_new_gen_req_pls),
        .self_algo_stop_create_new_gens_req_pls (self_algo_stop_create_new_gens_req_pls),
        .self_algo_chrom_mux_sel                (self_algo_chrom_mux_sel)
    );

    function automatic int dotModel(input logic [CHROM_MAX_W-1:0] w, input logic [CHROM_MAX_W-1:0] v);
        int acc = 0;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        for (int i = 0; i < M_MAX; i++) begin
            a = w[i*DATA_W +: DATA_W];
            b = v[i*DATA_W +: DATA_W];
            acc += int'($signed(a)) * int'($signed(b));
        end
        return acc;
    endfunction

    function automatic int limitOf(input int cfg);
        return (cfg == 0) ? 1 : cfg;
    endfunction

    // Reference model: phase 0 = off, 1 = gathering samples, 2 = evolving, 3 = publishing.
    int                     m_phase = 0;
    int                     m_gens = 0;
    int                     exp_cnt = 0;
    logic [CHROM_MAX_W-1:0] m_v = '0;
    logic [CHROM_MAX_W-1:0] m_best = '0;
    logic [CHROM_MAX_W-1:0] exp_w = '0;
    logic [Y_W-1:0]         exp_y = '0;
    logic exp_valid = 0, exp_ready = 0, exp_init = 0, exp_fit = 0;
    logic exp_req = 0, exp_stop = 0, exp_mux = 0;

    always @(posedge clk) begin
        exp_init <= 1'b0;
        exp_req  <= 1'b0;
        exp_stop <= 1'b0;
        if (rstn) begin
            m_phase <= 0; m_gens <= 0; exp_cnt <= 0; m_v <= '0; m_best <= '0;
            exp_w <= '0; exp_y <= '0; exp_valid <= 0; exp_ready <= 0;
            exp_fit <= 0; exp_mux <= 0;
        end else if (!i_ga_enable) begin
            m_phase <= 0; m_gens <= 0; exp_cnt <= 0;
            exp_valid <= 0; exp_ready <= 0; exp_fit <= 0; exp_mux <= 0;
        end else begin
            case (m_phase)
                0: begin
                    exp_init <= 1'b1; exp_ready <= 1'b1; m_phase <= 1;
                end
                1: if (i_valid_pls) begin
                    m_v     <= i_v_vec_flat_n;
                    exp_cnt <= (exp_cnt >= limitOf(int'(cnfg_b))) ? limitOf(int'(cnfg_b)) : exp_cnt + 1;
                    if (exp_cnt + 1 >= limitOf(int'(cnfg_b))) begin
                        m_phase <= 2; m_gens <= 0; exp_req <= 1'b1;
                        exp_ready <= 1'b0; exp_mux <= 1'b1; exp_fit <= 1'b1;
                    end
                end
                2: if (algo_self_gen_created_pls) begin
                    m_best <= algo_self_best_chrom;
                    m_gens <= m_gens + 1;
                    if (m_gens + 1 >= limitOf(int'(cnfg_g))) begin
                        exp_stop <= 1'b1; exp_mux <= 1'b0; m_phase <= 3;
                    end else begin
                        exp_req <= 1'b1;
                    end
                end
                default: begin
                    exp_w <= m_best;
                    exp_y <= Y_W'(dotModel(m_best, m_v));
                    exp_valid <= 1'b1; exp_ready <= 1'b1; m_phase <= 1;
                end
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [CHROM_MAX_W-1:0] act,
                               input logic [CHROM_MAX_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("valid_lvl", CHROM_MAX_W'(o_valid_lvl), CHROM_MAX_W'(exp_valid));
        checkOutput("ga_ready", CHROM_MAX_W'(o_ga_ready), CHROM_MAX_W'(exp_ready));
        checkOutput("w_vec", o_w_vec_np1, exp_w);
        checkOutput("y_n", CHROM_MAX_W'(o_y_n), CHROM_MAX_W'(exp_y));
        checkOutput("counter", CHROM_MAX_W'(o_inputs_counter), CHROM_MAX_W'(exp_cnt));
        checkOutput("init_pop", CHROM_MAX_W'(self_algo_init_pop_start), CHROM_MAX_W'(exp_init));
        checkOutput("fit_en", CHROM_MAX_W'(self_algo_fit_enable), CHROM_MAX_W'(exp_fit));
        checkOutput("gen_req", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), CHROM_MAX_W'(exp_req));
        checkOutput("stop_req", CHROM_MAX_W'(self_algo_stop_create_new_gens_req_pls), CHROM_MAX_W'(exp_stop));
        checkOutput("mux_sel", CHROM_MAX_W'(self_algo_chrom_mux_sel), CHROM_MAX_W'(exp_mux));
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            compareModel();
        end
    endtask

    task automatic sendSample(input int e0);
        i_v_vec_flat_n = CHROM_MAX_W'(e0 & 63);
        i_valid_pls    = 1'b1;
        applyStimulus(1);
        i_valid_pls    = 1'b0;
    endtask

    task automatic sendGen(input logic [CHROM_MAX_W-1:0] c);
        algo_self_best_chrom      = c;
        algo_self_gen_created_pls = 1'b1;
        applyStimulus(1);
        algo_self_gen_created_pls = 1'b0;
    endtask

    initial begin
        rstn = 1'b1; cnfg_b = '0; cnfg_g = '0; i_ga_enable = 1'b0; i_valid_pls = 1'b0;
        i_v_vec_flat_n = '0; algo_self_gen_created_pls = 1'b0; algo_self_best_chrom = '0;
        applyStimulus(2);
        checkOutput("rst_counter", CHROM_MAX_W'(o_inputs_counter), '0);
        checkOutput("rst_valid", CHROM_MAX_W'(o_valid_lvl), '0);

        rstn = 1'b0; cnfg_b = 3; cnfg_g = 4; i_ga_enable = 1'b1;
        applyStimulus(1);
        checkOutput("en_init_pop", CHROM_MAX_W'(self_algo_init_pop_start), 1);
        checkOutput("en_ready", CHROM_MAX_W'(o_ga_ready), 1);
        applyStimulus(1);
        checkOutput("init_pop_once", CHROM_MAX_W'(self_algo_init_pop_start), 0);

        sendSample(1);
        checkOutput("cnt_1", CHROM_MAX_W'(o_inputs_counter), 1);
        sendSample(2);
        checkOutput("cnt_2", CHROM_MAX_W'(o_inputs_counter), 2);
        applyStimulus(2);
        sendSample(2);
        checkOutput("cnt_3", CHROM_MAX_W'(o_inputs_counter), 3);
        checkOutput("run_req", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), 1);
        checkOutput("run_ready", CHROM_MAX_W'(o_ga_ready), 0);
        checkOutput("run_mux", CHROM_MAX_W'(self_algo_chrom_mux_sel), 1);
        applyStimulus(1);

        sendSample(7);
        checkOutput("run_ignores_sample", CHROM_MAX_W'(o_inputs_counter), 3);
        for (int k = 1; k <= 4; k++) begin
            sendGen(CHROM_MAX_W'(k * 111));
            if (k < 4) checkOutput("gen_req_k", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), 1);
            else       checkOutput("stop_k4", CHROM_MAX_W'(self_algo_stop_create_new_gens_req_pls), 1);
            applyStimulus(1);
        end
        checkOutput("w_444", o_w_vec_np1, 444);
        checkOutput("y_run1", CHROM_MAX_W'(o_y_n), CHROM_MAX_W'(17'h1FFF8));
        checkOutput("valid_run1", CHROM_MAX_W'(o_valid_lvl), 1);
        checkOutput("ready_run1", CHROM_MAX_W'(o_ga_ready), 1);

        sendSample(9);
        checkOutput("rerun_req", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), 1);
        applyStimulus(1);
        for (int k = 5; k <= 8; k++) begin
            sendGen(CHROM_MAX_W'(k * 111));
            applyStimulus(1);
        end
        checkOutput("w_888", o_w_vec_np1, 888);
        checkOutput("y_run2", CHROM_MAX_W'(o_y_n), CHROM_MAX_W'(17'h1FFB8));

        sendGen(CHROM_MAX_W'(999));
        checkOutput("collect_ignores_gen", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), 0);
        applyStimulus(1);
        checkOutput("w_hold", o_w_vec_np1, 888);

        sendSample(4);
        sendGen(CHROM_MAX_W'(1));
        applyStimulus(1);
        sendGen(CHROM_MAX_W'(2));
        i_ga_enable = 1'b0;
        applyStimulus(1);
        checkOutput("dis_counter", CHROM_MAX_W'(o_inputs_counter), 0);
        checkOutput("dis_valid", CHROM_MAX_W'(o_valid_lvl), 0);
        checkOutput("dis_fit", CHROM_MAX_W'(self_algo_fit_enable), 0);
        applyStimulus(1);
        i_ga_enable = 1'b1; cnfg_b = 0; cnfg_g = 0;
        applyStimulus(1);
        checkOutput("reen_init_pop", CHROM_MAX_W'(self_algo_init_pop_start), 1);

        sendSample(5);
        checkOutput("b0_cnt", CHROM_MAX_W'(o_inputs_counter), 1);
        checkOutput("b0_req", CHROM_MAX_W'(self_algo_create_new_gen_req_pls), 1);
        sendGen(CHROM_MAX_W'(63));
        checkOutput("g0_stop", CHROM_MAX_W'(self_algo_stop_create_new_gens_req_pls), 1);
        applyStimulus(1);
        checkOutput("g0_w", o_w_vec_np1, 63);
        checkOutput("g0_y", CHROM_MAX_W'(o_y_n), CHROM_MAX_W'(17'h1FFFB));
        applyStimulus(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
